matrix_capture: RTL and testbench
=================================

Name: matrix_capture

Overview:
- Receive-side model of the 16x16 LED matrix serial interface (RCLK/RSDI, CCLK/CSDI, LE, OEB) that the pong core drives.
- Deserialises the row-select and column-data shift streams and latches each completed row into a 16x16 frame buffer on LE.
- Exposes the frame buffer, a frame counter and protocol-error status to the Caravel logic analyser / test benches, so the matrix output can be checked on silicon without the physical display.

Parameters:
- SYNC_STAGES, 2, synchroniser flops per serial input (minimum 2).
- FRAME_CNT_W, 16, width of frame_count.

Ports:
- clk32mhz  input  1  system clock (wb_clk_i domain)
- reset_n  input  1  asynchronous active-low reset
- rclk  input  1  row shift clock, asynchronous
- rsdi  input  1  row serial data, asynchronous
- cclk  input  1  column shift clock, asynchronous
- csdi  input  1  column serial data, asynchronous
- le  input  1  latch enable, asynchronous
- oeb  input  1  output enable bar, asynchronous
- rd_row  input  4  frame-buffer row to read
- rd_data  output  16  registered contents of row rd_row; bit i = column i
- frame_strobe  output  1  one-cycle pulse when row 15 is latched
- frame_count  output  FRAME_CNT_W  frames completed, wraps
- err_clear  input  1  synchronous clear of err_multi_row
- err_multi_row  output  1  sticky: a latched row select had more than one bit set
- blank  output  1  synchronised oeb

Behaviour:
- Reset (reset_n low, async): shift registers, frame buffer, rd_data, frame_count, frame_strobe and err_multi_row all 0; blank = 1. Synchroniser flops reset to 0.
- All six serial inputs pass through SYNC_STAGES flops. Rising edges of rclk, cclk and le are detected one cycle after the last sync stage. Data is sampled from the same sync stage as its clock.
- Sender timing constraint: each rclk/cclk/le high and low phase must last at least SYNC_STAGES+1 clk32mhz cycles. Data must be stable for at least 1 cycle around its clock edge.
- rclk rise: row_sr <= {row_sr[14:0], rsdi}.
- cclk rise: col_sr <= {col_sr[14:0], csdi}. MSB-first: the first bit shifted ends in bit 15 (column 15) after 16 clocks.
- Shift registers keep shifting past 16 clocks; only the last 16 bits count.
- le rise latches the current pre-update row_sr/col_sr. If a shift edge occurs in the same cycle, the latch uses the old value and the shift still occurs.
- Action on le rise, by row_sr value:
  - Exactly one bit r set: fb[r] <= col_sr, written on the detect cycle.
  - row_sr == 0: blanking row; no write and no error.
  - More than one bit set: no write; err_multi_row <= 1.
- Total latency from le pin rise to frame-buffer update: SYNC_STAGES+1 cycles.
- frame_strobe pulses in the same cycle as a valid write to row 15. frame_count increments on that pulse and wraps from all-ones to 0.
- err_clear: clears err_multi_row next cycle. If a new error occurs in the same cycle, set wins.
- rd_data <= fb[rd_row] every cycle (1-cycle latency). A read of the row being written in the same cycle returns the old data.
- blank = synchronised oeb. It does not gate capture; the frame buffer reflects latched data whether or not the display is enabled.
- No state machine beyond the shift and latch registers; no handshake back to the sender.
- reset_n asserted mid-stream discards partial shifts. After release, the first le latches whatever has been shifted since release.

Decomposition:
- Package matrix_pkg holds MATRIX_SIZE = 16, ROW_IDX_W = 4, and a popcount-based onehot check function. Shared with the pong matrix driver.
- Sub-module sync_edge: SYNC_STAGES synchroniser plus rising-edge detect, with outputs level and rise. Instantiated once per serial input (six instances).

Test Plan:
- Shift row_sr = 16'h0004 and col_sr = 16'hA5C3, then pulse le -> after SYNC_STAGES+1 cycles fb[2] = 16'hA5C3; rd_row = 2 gives rd_data = 16'hA5C3 one cycle later; err_multi_row = 0.
- Send rows 0..15 with col = 16'h0001 << r, latching each -> frame_strobe pulses once on row 15; frame_count = 1; fb forms the identity diagonal.
- Shift row_sr = 16'h0005, any columns, pulse le -> no fb change, err_multi_row = 1. Pulse err_clear -> 0 next cycle. err_clear coincident with a new error -> stays 1.
- Shift row_sr = 16'h0000 and pulse le -> no write, no error. Send 20 cclk bits -> only the last 16 are latched.
- Assert reset_n mid-row after 8 bits -> all outputs return to reset values, blank = 1. A full 16-bit row after release latches correctly.
- Force frame_count to the all-ones value (FRAME_CNT_W = 4 build) and complete one more frame -> frame_count = 0 and frame_strobe = 1 for exactly one cycle.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the 16x16 LED matrix serial interface (driver and capture sides).
package matrix_pkg;

    localparam int unsigned MATRIX_SIZE = 16;
    localparam int unsigned ROW_IDX_W   = 4;
    localparam int unsigned CNT_W       = ROW_IDX_W + 1;

    typedef logic [MATRIX_SIZE-1:0] row_t;

    // One frame-buffer row write produced by a latch event
    typedef struct packed {
        logic                 en;
        logic [ROW_IDX_W-1:0] idx;
        row_t                 data;
    } row_wr_t;

    function automatic logic is_onehot(input row_t v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < MATRIX_SIZE; i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return (cnt == CNT_W'(1));
    endfunction

    function automatic logic [ROW_IDX_W-1:0] onehot_idx(input row_t v);
        logic [ROW_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MATRIX_SIZE; i++) begin
            if (v[i]) begin
                idx = ROW_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/matrix_capture_if.sv
// Serial LED-matrix pin bundle: the pong driver is the master, the capture block the slave.
interface matrix_capture_if;
    logic rclk;
    logic rsdi;
    logic cclk;
    logic csdi;
    logic le;
    logic oeb;

    modport master (output rclk, rsdi, cclk, csdi, le, oeb);
    modport slave  (input  rclk, rsdi, cclk, csdi, le, oeb);
endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with a registered rising-edge pulse
// that is high in the first cycle the synchronised level reads 1.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rise_q, rise_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
        rise_d = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            rise_q <= rise_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = rise_q;

endmodule

// File: rtl/matrix_capture.sv
// Receive-side model of the LED matrix serial link: deserialises row/column streams and
// latches each completed row into a readable 16x16 frame buffer.
module matrix_capture
    import matrix_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FRAME_CNT_W = 16
) (
    input  logic                   clk32mhz,
    input  logic                   reset_n,
    matrix_capture_if.slave        mif,
    input  logic [ROW_IDX_W-1:0]   rd_row,
    output row_t                   rd_data,
    output logic                   frame_strobe,
    output logic [FRAME_CNT_W-1:0] frame_count,
    input  logic                   err_clear,
    output logic                   err_multi_row,
    output logic                   blank
);

    logic rclk_rise, cclk_rise, le_rise;
    logic rsdi_lvl, csdi_lvl, oeb_lvl;
    logic rclk_lvl_unused, cclk_lvl_unused, le_lvl_unused;
    logic rsdi_rise_unused, csdi_rise_unused, oeb_rise_unused;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rclk (
        .clk(clk32mhz), .rst_n(reset_n), .d(mif.rclk), .level(rclk_lvl_unused), .rise(rclk_rise));
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rsdi (
        .clk(clk32mhz), .rst_n(reset_n), .d(mif.rsdi), .level(rsdi_lvl), .rise(rsdi_rise_unused));
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cclk (
        .clk(clk32mhz), .rst_n(reset_n), .d(mif.cclk), .level(cclk_lvl_unused), .rise(cclk_rise));
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_csdi (
        .clk(clk32mhz), .rst_n(reset_n), .d(mif.csdi), .level(csdi_lvl), .rise(csdi_rise_unused));
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_le (
        .clk(clk32mhz), .rst_n(reset_n), .d(mif.le), .level(le_lvl_unused), .rise(le_rise));
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_oeb (
        .clk(clk32mhz), .rst_n(reset_n), .d(mif.oeb), .level(oeb_lvl), .rise(oeb_rise_unused));

    row_t                   row_sr_q, row_sr_d;
    row_t                   col_sr_q, col_sr_d;
    row_t                   fb_q [MATRIX_SIZE];
    row_t                   fb_d [MATRIX_SIZE];
    row_t                   rd_data_q, rd_data_d;
    logic                   frame_strobe_q, frame_strobe_d;
    logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
    logic                   err_q, err_d;
    logic                   blank_q, blank_d;
    row_wr_t                wr;

    // Latch decisions use the pre-shift registers, so a coincident shift edge is not seen
    always_comb begin
        row_sr_d       = row_sr_q;
        col_sr_d       = col_sr_q;
        fb_d           = fb_q;
        frame_count_d  = frame_count_q;
        err_d          = err_q;
        wr.en          = le_rise & is_onehot(row_sr_q);
        wr.idx         = onehot_idx(row_sr_q);
        wr.data        = col_sr_q;

        if (rclk_rise) begin
            row_sr_d = {row_sr_q[MATRIX_SIZE-2:0], rsdi_lvl};
        end
        if (cclk_rise) begin
            col_sr_d = {col_sr_q[MATRIX_SIZE-2:0], csdi_lvl};
        end
        if (wr.en) begin
            fb_d[wr.idx] = wr.data;
        end

        frame_strobe_d = wr.en && (wr.idx == ROW_IDX_W'(MATRIX_SIZE - 1));
        if (frame_strobe_d) begin
            frame_count_d = frame_count_q + FRAME_CNT_W'(1);
        end

        // Set after clear so a simultaneous new error stays visible
        if (err_clear) begin
            err_d = 1'b0;
        end
        if (le_rise && (row_sr_q != '0) && !is_onehot(row_sr_q)) begin
            err_d = 1'b1;
        end

        rd_data_d = fb_q[rd_row];
        blank_d   = oeb_lvl;
    end

    always_ff @(posedge clk32mhz or negedge reset_n) begin
        if (!reset_n) begin
            row_sr_q       <= '0;
            col_sr_q       <= '0;
            fb_q           <= '{default: '0};
            rd_data_q      <= '0;
            frame_strobe_q <= 1'b0;
            frame_count_q  <= '0;
            err_q          <= 1'b0;
            blank_q        <= 1'b1;
        end else begin
            row_sr_q       <= row_sr_d;
            col_sr_q       <= col_sr_d;
            fb_q           <= fb_d;
            rd_data_q      <= rd_data_d;
            frame_strobe_q <= frame_strobe_d;
            frame_count_q  <= frame_count_d;
            err_q          <= err_d;
            blank_q        <= blank_d;
        end
    end

    assign rd_data       = rd_data_q;
    assign frame_strobe  = frame_strobe_q;
    assign frame_count   = frame_count_q;
    assign err_multi_row = err_q;
    assign blank         = blank_q;

endmodule

// File: tb/tb_matrix_capture.sv
// Scoreboard bench for matrix_capture: directed serial streams, expected values queued at
// issue time and checked by an independent monitor on the falling clock edge.
module tb_matrix_capture;
    import matrix_pkg::*;

    localparam int unsigned SYNC = 2;
    localparam int unsigned CW   = 4;
    localparam int unsigned PH   = SYNC + 2;

    typedef enum logic [1:0] {K_RD, K_ERR, K_BLANK, K_CNT} kind_e;
    typedef struct packed {
        kind_e       kind;
        logic [15:0] exp;
    } chk_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    rd_row;
    row_t          rd_data;
    logic          frame_strobe;
    logic [CW-1:0] frame_count;
    logic          err_clear;
    logic          err_multi_row;
    logic          blank;

    matrix_capture_if mif ();

    matrix_capture #(.SYNC_STAGES(SYNC), .FRAME_CNT_W(CW)) dut (
        .clk32mhz     (clk),
        .reset_n      (rst_n),
        .mif          (mif),
        .rd_row       (rd_row),
        .rd_data      (rd_data),
        .frame_strobe (frame_strobe),
        .frame_count  (frame_count),
        .err_clear    (err_clear),
        .err_multi_row(err_multi_row),
        .blank        (blank)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic          chk_req = 1'b0;
    chk_t          chk_q[$];
    string         name_q[$];
    logic [CW-1:0] strobe_q[$];
    logic [CW-1:0] exp_cnt = '0;

    // Monitor: compares queued expectations and every frame_strobe pulse
    always @(negedge clk) begin
        chk_t        c;
        string       nm;
        logic [15:0] got;
        if (chk_req) begin
            n_tests++;
            if (chk_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_underflow: got check request, required queued expectation");
            end else begin
                c  = chk_q.pop_front();
                nm = name_q.pop_front();
                got = '0;
                case (c.kind)
                    K_RD:    got = rd_data;
                    K_ERR:   got[0] = err_multi_row;
                    K_BLANK: got[0] = blank;
                    default: got = 16'(frame_count);
                endcase
                if (got !== c.exp) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%04h, required 0x%04h", nm, got, c.exp);
                end
            end
        end
        if (frame_strobe === 1'b1) begin
            n_tests++;
            if (strobe_q.size() == 0) begin
                n_fail++;
                $display("FAIL frame_strobe_unexpected: got pulse with frame_count %0d, required none", frame_count);
            end else begin
                logic [CW-1:0] e;
                e = strobe_q.pop_front();
                if (frame_count !== e) begin
                    n_fail++;
                    $display("FAIL frame_strobe_count: got %0d, required %0d", frame_count, e);
                end
            end
        end
    end

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_sig(input kind_e k, input logic [15:0] e, input string nm);
        chk_q.push_back('{kind: k, exp: e});
        name_q.push_back(nm);
        chk_req = 1'b1;
        wait_cyc(1);
        chk_req = 1'b0;
    endtask

    task automatic read_row(input int r, input logic [15:0] e);
        rd_row = 4'(r);
        wait_cyc(1);
        expect_sig(K_RD, e, $sformatf("rd_row%0d", r));
    endtask

    task automatic shift_row(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mif.rsdi = v[i];
            wait_cyc(PH);
            mif.rclk = 1'b1;
            wait_cyc(PH);
            mif.rclk = 1'b0;
        end
    endtask

    task automatic shift_col(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mif.csdi = v[i];
            wait_cyc(PH);
            mif.cclk = 1'b1;
            wait_cyc(PH);
            mif.cclk = 1'b0;
        end
    endtask

    task automatic pulse_le();
        mif.le = 1'b1;
        wait_cyc(PH);
        mif.le = 1'b0;
        wait_cyc(PH);
    endtask

    task automatic latch(input logic [15:0] row, input logic [15:0] col);
        shift_row(32'(row), 16);
        shift_col(32'(col), 16);
        pulse_le();
    endtask

    initial begin
        mif.rclk = 1'b0; mif.rsdi = 1'b0; mif.cclk = 1'b0; mif.csdi = 1'b0;
        mif.le = 1'b0;   mif.oeb = 1'b1;
        rd_row = '0; err_clear = 1'b0; rst_n = 1'b0;
        wait_cyc(3);
        expect_sig(K_BLANK, 16'h0001, "blank_in_reset");
        rst_n = 1'b1;
        wait_cyc(4);
        expect_sig(K_ERR, 16'h0000, "err_reset");
        expect_sig(K_CNT, 16'h0000, "count_reset");
        read_row(0, 16'h0000);
        expect_sig(K_BLANK, 16'h0001, "blank_oeb_high");
        mif.oeb = 1'b0;
        wait_cyc(5);
        expect_sig(K_BLANK, 16'h0000, "blank_oeb_low");

        // Single row write
        latch(16'h0004, 16'hA5C3);
        read_row(2, 16'hA5C3);
        expect_sig(K_ERR, 16'h0000, "err_after_row2");

        // Identity diagonal; row 15 completes frame 1
        for (int r = 0; r < 16; r++) begin
            if (r == 15) begin
                exp_cnt = exp_cnt + 1'b1;
                strobe_q.push_back(exp_cnt);
            end
            latch(16'(16'h0001 << r), 16'(16'h0001 << r));
        end
        for (int r = 0; r < 16; r++) read_row(r, 16'(16'h0001 << r));
        expect_sig(K_CNT, 16'h0001, "count_after_frame");

        // Multi-row select: no write, sticky error, clear, and set-beats-clear
        latch(16'h0005, 16'hFFFF);
        read_row(0, 16'h0001);
        read_row(2, 16'h0004);
        expect_sig(K_ERR, 16'h0001, "err_multi_set");
        err_clear = 1'b1;
        wait_cyc(1);
        err_clear = 1'b0;
        expect_sig(K_ERR, 16'h0000, "err_cleared");
        mif.le = 1'b1;
        wait_cyc(1);
        err_clear = 1'b1;
        wait_cyc(2);
        err_clear = 1'b0;
        wait_cyc(PH);
        mif.le = 1'b0;
        wait_cyc(PH);
        expect_sig(K_ERR, 16'h0001, "err_set_beats_clear");
        err_clear = 1'b1;
        wait_cyc(1);
        err_clear = 1'b0;

        // Blanking row, then 20 column bits of which only the last 16 survive
        latch(16'h0000, 16'hBEEF);
        read_row(0, 16'h0001);
        read_row(15, 16'h8000);
        expect_sig(K_ERR, 16'h0000, "err_blank_row");
        shift_col(32'h000ABCDE, 20);
        shift_row(32'h00000040, 16);
        pulse_le();
        read_row(6, 16'hBCDE);

        // Reset mid-row discards the partial shift
        shift_row(32'h000000FF, 8);
        shift_col(32'h000000FF, 8);
        rst_n = 1'b0;
        exp_cnt = '0;
        wait_cyc(2);
        expect_sig(K_BLANK, 16'h0001, "blank_mid_reset");
        expect_sig(K_ERR, 16'h0000, "err_mid_reset");
        expect_sig(K_CNT, 16'h0000, "count_mid_reset");
        rst_n = 1'b1;
        wait_cyc(2);
        read_row(6, 16'h0000);
        read_row(15, 16'h0000);
        shift_row(32'h00000008, 8);
        shift_col(32'h0000005A, 8);
        pulse_le();
        read_row(3, 16'h005A);
        expect_sig(K_ERR, 16'h0000, "err_after_partial");
        latch(16'h0800, 16'h1234);
        read_row(11, 16'h1234);

        // Frame counter wrap: 16 row-15 latches on a 4-bit counter
        shift_row(32'h00008000, 16);
        shift_col(32'h000000FF, 16);
        for (int k = 0; k < 16; k++) begin
            exp_cnt = exp_cnt + 1'b1;
            strobe_q.push_back(exp_cnt);
            pulse_le();
        end
        expect_sig(K_CNT, 16'h0000, "count_wrapped");
        read_row(15, 16'h00FF);

        wait_cyc(10);
        n_tests++;
        if (strobe_q.size() != 0) begin
            n_fail++;
            $display("FAIL frame_strobe_missing: got %0d outstanding, required 0", strobe_q.size());
        end
        n_tests++;
        if (chk_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d outstanding, required 0", chk_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
